// File: rtl/sata_link_rxbuf_sf.sv
// Link-layer receive buffer between rdmod and the transport layer: FIFO with
// hysteretic HOLD request, optional store-and-forward commit/rollback per frame.
module sata_link_rxbuf_sf #(
  parameter int DATA_W    = 32,
  parameter int USER_W    = 8,
  parameter int DEPTH     = 64,
  parameter int FULL_THR  = DEPTH - 24,
  parameter int REL_THR   = DEPTH / 2,
  parameter bit STORE_FWD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        s_aixs_tdata,
  input  logic [USER_W-1:0]        s_aixs_tuser,
  input  logic                     s_aixs_tvalid,
  output logic                     s_aixs_tready,
  output logic [DATA_W-1:0]        m_aixs_tdata,
  output logic [USER_W-1:0]        m_aixs_tuser,
  output logic                     m_aixs_tvalid,
  input  logic                     m_aixs_tready,
  output logic                     buffer_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frm_drop,
  output logic [15:0]              drop_cnt,
  output logic [1:0]               fsm_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = USER_W + DATA_W;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] FULL_L  = PW'(FULL_THR);
  localparam logic [PW-1:0] REL_L   = PW'(REL_THR);
  localparam logic [PW-1:0] ONE     = PW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, IN_FRAME = 2'd1, DISCARD = 2'd2} state_t;

  // Handshake: a beat transfers on the rising edge where tvalid and tready are
  // both high; tvalid never depends on tready and the master holds its beat
  // (data and sideband stable) until it transfers.
  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, wr_cmt, rd_ptr;
  logic [PW-1:0]   wr_ptr_nxt, wr_cmt_nxt, rd_ptr_nxt, level_nxt;
  logic [MW-1:0]   mem [DEPTH];
  logic [MW-1:0]   ram_q;
  logic            ram_vld;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic            drop_nxt, cnt_inc;
  logic            wr_fire, rd_en, out_load;
  logic            in_sop, in_eop, in_bad;

  assign in_eop   = s_aixs_tuser[0];
  assign in_sop   = s_aixs_tuser[1];
  assign in_bad   = s_aixs_tuser[6] | s_aixs_tuser[7];
  assign wr_fire  = s_aixs_tvalid & s_aixs_tready;
  assign level    = wr_ptr - rd_ptr;
  assign fsm_state = state;

  // wr_cmt is the readable limit in both modes; cut-through advances it per beat.
  assign out_load   = ram_vld & (~m_aixs_tvalid | m_aixs_tready);
  assign rd_en      = (rd_ptr != wr_cmt) & (~ram_vld | out_load);
  assign rd_ptr_nxt = rd_ptr + (rd_en ? ONE : '0);
  assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    wr_cmt_nxt = wr_cmt;
    mem_we     = 1'b0;
    mem_wa     = wr_ptr[AW-1:0];
    drop_nxt   = 1'b0;
    cnt_inc    = 1'b0;
    if (!STORE_FWD) begin
      if (wr_fire) begin
        mem_we     = 1'b1;
        wr_ptr_nxt = wr_ptr + ONE;
        wr_cmt_nxt = wr_ptr + ONE;
        if (in_eop)      state_nxt = IDLE;
        else if (in_sop) state_nxt = IN_FRAME;
      end
    end else if (state == IN_FRAME && level == DEPTH_L && wr_cmt == rd_ptr) begin
      // The open frame alone fills the buffer: it can never be committed.
      wr_ptr_nxt = wr_cmt;
      drop_nxt   = 1'b1;
      cnt_inc    = 1'b1;
      state_nxt  = DISCARD;
    end else if (wr_fire) begin
      if (in_sop) begin
        // Outside a frame wr_ptr equals wr_cmt, so a start always lands at wr_cmt.
        if (state == IN_FRAME) drop_nxt = 1'b1;
        if (in_eop && in_bad) begin
          wr_ptr_nxt = wr_cmt;
          drop_nxt   = 1'b1;
          cnt_inc    = 1'b1;
          state_nxt  = IDLE;
        end else begin
          mem_we     = 1'b1;
          mem_wa     = wr_cmt[AW-1:0];
          wr_ptr_nxt = wr_cmt + ONE;
          if (in_eop) begin
            wr_cmt_nxt = wr_cmt + ONE;
            state_nxt  = IDLE;
          end else begin
            state_nxt  = IN_FRAME;
          end
        end
      end else if (state == IN_FRAME) begin
        if (in_eop && in_bad) begin
          wr_ptr_nxt = wr_cmt;
          drop_nxt   = 1'b1;
          cnt_inc    = 1'b1;
          state_nxt  = IDLE;
        end else begin
          mem_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + ONE;
          if (in_eop) begin
            wr_cmt_nxt = wr_ptr + ONE;
            state_nxt  = IDLE;
          end
        end
      end else if (state == DISCARD) begin
        if (in_eop) state_nxt = IDLE;
      end else begin
        drop_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= {s_aixs_tuser, s_aixs_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      wr_cmt        <= '0;
      rd_ptr        <= '0;
      s_aixs_tready <= 1'b0;
      buffer_full   <= 1'b0;
      frm_drop      <= 1'b0;
      drop_cnt      <= '0;
      ram_q         <= '0;
      ram_vld       <= 1'b0;
      m_aixs_tvalid <= 1'b0;
      m_aixs_tdata  <= '0;
      m_aixs_tuser  <= '0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_ptr_nxt;
      wr_cmt        <= wr_cmt_nxt;
      rd_ptr        <= rd_ptr_nxt;
      s_aixs_tready <= (level_nxt != DEPTH_L) || (state_nxt == DISCARD);
      if (level >= FULL_L)     buffer_full <= 1'b1;
      else if (level < REL_L)  buffer_full <= 1'b0;
      frm_drop <= drop_nxt;
      if (cnt_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (rd_en) begin
        ram_q   <= mem[rd_ptr[AW-1:0]];
        ram_vld <= 1'b1;
      end else if (out_load) begin
        ram_vld <= 1'b0;
      end
      if (out_load) begin
        m_aixs_tvalid                <= 1'b1;
        {m_aixs_tuser, m_aixs_tdata} <= ram_q;
      end else if (m_aixs_tready) begin
        m_aixs_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sata_link_rxbuf_sf.sv
// Directed bench for sata_link_rxbuf_sf: store-and-forward instance plus a
// cut-through instance, each with its own expected-beat queue.
module tb_sata_link_rxbuf_sf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] s_tdata, m_tdata;
  logic [7:0]  s_tuser, m_tuser;
  logic        s_tvalid, s_tready, m_tvalid, m_tready;
  logic        buffer_full, frm_drop;
  logic [6:0]  level;
  logic [15:0] drop_cnt;
  logic [1:0]  fsm_state;

  logic [31:0] c_s_tdata, c_m_tdata;
  logic [7:0]  c_s_tuser, c_m_tuser;
  logic        c_s_tvalid, c_s_tready, c_m_tvalid, c_m_tready;
  logic        c_buffer_full, c_frm_drop;
  logic [6:0]  c_level;
  logic [15:0] c_drop_cnt;
  logic [1:0]  c_fsm_state;

  logic [39:0] exp_q[$];
  logic [39:0] exp_ct_q[$];
  logic [7:0]  last_ct_user;
  int          n_checks = 0;
  int          n_errors = 0;
  int          drop_pulses = 0;
  int          pulses_0;
  bit          found;

  always #5 clk = ~clk;

  sata_link_rxbuf_sf dut (
    .clk(clk), .rst_n(rst_n),
    .s_aixs_tdata(s_tdata), .s_aixs_tuser(s_tuser), .s_aixs_tvalid(s_tvalid), .s_aixs_tready(s_tready),
    .m_aixs_tdata(m_tdata), .m_aixs_tuser(m_tuser), .m_aixs_tvalid(m_tvalid), .m_aixs_tready(m_tready),
    .buffer_full(buffer_full), .level(level), .frm_drop(frm_drop), .drop_cnt(drop_cnt),
    .fsm_state(fsm_state)
  );

  sata_link_rxbuf_sf #(.STORE_FWD(1'b0)) dut_ct (
    .clk(clk), .rst_n(rst_n),
    .s_aixs_tdata(c_s_tdata), .s_aixs_tuser(c_s_tuser), .s_aixs_tvalid(c_s_tvalid), .s_aixs_tready(c_s_tready),
    .m_aixs_tdata(c_m_tdata), .m_aixs_tuser(c_m_tuser), .m_aixs_tvalid(c_m_tvalid), .m_aixs_tready(c_m_tready),
    .buffer_full(c_buffer_full), .level(c_level), .frm_drop(c_frm_drop), .drop_cnt(c_drop_cnt),
    .fsm_state(c_fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("unexpected_beat", m_tvalid, 1'b0);
      else check("rd_beat", {m_tuser, m_tdata}, exp_q.pop_front());
    end
    if (rst_n && c_m_tvalid && c_m_tready) begin
      last_ct_user = c_m_tuser;
      if (exp_ct_q.size() == 0) check("ct_unexpected_beat", c_m_tvalid, 1'b0);
      else check("ct_rd_beat", {c_m_tuser, c_m_tdata}, exp_ct_q.pop_front());
    end
    if (frm_drop) drop_pulses++;
  end

  task automatic send_beat(input bit ct, input logic [31:0] d, input logic [7:0] u);
    int n = 0;
    if (ct) begin c_s_tdata = d; c_s_tuser = u; c_s_tvalid = 1'b1; end
    else begin s_tdata = d; s_tuser = u; s_tvalid = 1'b1; end
    @(negedge clk);
    while (!(ct ? c_s_tready : s_tready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("tready_timeout", ct ? c_s_tready : s_tready, 1'b1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    c_s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input bit ct, input int n, input logic [31:0] base,
                            input logic [7:0] last_flags, input bit push);
    logic [7:0] u;
    for (int i = 0; i < n; i++) begin
      u = 8'h3C;
      if (i == 0) u = u | 8'h02;
      if (i == n - 1) u = u | 8'h01 | last_flags;
      if (push) begin
        if (ct) exp_ct_q.push_back({u, base + 32'(i)});
        else exp_q.push_back({u, base + 32'(i)});
      end
      send_beat(ct, base + 32'(i), u);
    end
  endtask

  task automatic wait_drain(input bit ct);
    int n = 0;
    while ((ct ? exp_ct_q.size() : exp_q.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(ct ? "ct_drain" : "drain", ct ? exp_ct_q.size() : exp_q.size(), 0);
  endtask

  task automatic clean_frame(input logic [31:0] base);
    send_frame(1'b0, 4, base, 8'h00, 1'b1);
    check("lat_eop", m_tvalid, 1'b0);
    @(posedge clk); #1;
    check("lat_eop_p1", m_tvalid, 1'b0);
    @(posedge clk); #1;
    check("lat_eop_p2", m_tvalid, 1'b1);
    wait_drain(1'b0);
    check("clean_drop_cnt", drop_cnt, 16'd0);
    check("clean_level", level, 7'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; m_tready = 1'b0;
    c_s_tvalid = 1'b0; c_s_tdata = '0; c_s_tuser = '0; c_m_tready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_buffer_full", buffer_full, 1'b0);
    check("rst_level", level, 7'd0);
    check("rst_drop_cnt", drop_cnt, 16'd0);
    check("rst_frm_drop", frm_drop, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rel_s_tready_low", s_tready, 1'b0);
    @(posedge clk); #1;
    check("rel_s_tready_high", s_tready, 1'b1);

    // 1: clean 4-dword frame
    m_tready = 1'b1;
    clean_frame(32'hA000_0000);

    // 2: frame with err on eop is rolled back
    pulses_0 = drop_pulses;
    send_frame(1'b0, 4, 32'hB000_0000, 8'h40, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("err_pulses", drop_pulses - pulses_0, 1);
    check("err_drop_cnt", drop_cnt, 16'd1);
    check("err_level", level, 7'd0);
    check("err_state", fsm_state, 2'd0);

    // stray non-sop beat outside a frame
    pulses_0 = drop_pulses;
    send_beat(1'b0, 32'h1234_5678, 8'h3C);
    repeat (2) @(posedge clk); #1;
    check("stray_pulses", drop_pulses - pulses_0, 1);
    check("stray_drop_cnt", drop_cnt, 16'd1);
    check("stray_level", level, 7'd0);

    // 3: oversized frame overflows into DISCARD
    m_tready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send_beat(1'b0, 32'hC000_0000 + 32'(i), (i == 0) ? 8'h3E : 8'h3C);
      if (i == 39) begin
        check("ovf_level40", level, 7'd40);
        check("ovf_bf_before", buffer_full, 1'b0);
      end
      if (i == 40) check("ovf_bf_set", buffer_full, 1'b1);
    end
    check("ovf_level64", level, 7'd64);
    check("ovf_tready_low", s_tready, 1'b0);
    @(posedge clk); #1;
    check("ovf_level0", level, 7'd0);
    check("ovf_state_discard", fsm_state, 2'd2);
    check("ovf_frm_drop", frm_drop, 1'b1);
    check("ovf_drop_cnt", drop_cnt, 16'd2);
    check("ovf_tready_high", s_tready, 1'b1);
    send_beat(1'b0, 32'hC000_00FF, 8'h3D);
    check("ovf_eop_idle", fsm_state, 2'd0);
    check("ovf_eop_level", level, 7'd0);
    check("ovf_bf_clear", buffer_full, 1'b0);
    check("ovf_no_out", m_tvalid, 1'b0);

    // 4: hysteresis release while draining a committed 40-dword frame
    send_frame(1'b0, 40, 32'hD000_0000, 8'h00, 1'b1);
    @(posedge clk); #1;
    check("hys_bf_set", buffer_full, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("hys_out_held", m_tvalid, 1'b1);
    check("hys_bf_still", buffer_full, 1'b1);
    m_tready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      if (level == 7'd31) begin
        found = 1'b1;
        check("hys_bf_at31", buffer_full, 1'b1);
        @(negedge clk);
        check("hys_bf_released", buffer_full, 1'b0);
      end
    end
    check("hys_reach31", found, 1'b1);
    wait_drain(1'b0);

    // 6: reset mid-frame with committed data held
    m_tready = 1'b0;
    send_frame(1'b0, 10, 32'hE000_0000, 8'h00, 1'b1);
    send_beat(1'b0, 32'hE100_0000, 8'h3E);
    send_beat(1'b0, 32'hE100_0001, 8'h3C);
    repeat (3) @(posedge clk); #1;
    check("mid_out_valid", m_tvalid, 1'b1);
    check("mid_level", level, 7'd10);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_tvalid", m_tvalid, 1'b0);
    check("mid_rst_level", level, 7'd0);
    @(posedge clk); #1;
    check("mid_rst_tvalid_p1", m_tvalid, 1'b0);
    check("mid_rst_tready", s_tready, 1'b0);
    check("mid_rst_drop_cnt", drop_cnt, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_tready", s_tready, 1'b1);
    clean_frame(32'hF000_0000);

    // 5: cut-through passes a dropped frame unchanged
    send_frame(1'b1, 3, 32'h5500_0000, 8'h80, 1'b1);
    wait_drain(1'b1);
    check("ct_last_user", last_ct_user, 8'hBD);
    check("ct_drop_cnt", c_drop_cnt, 16'd0);
    check("ct_level", c_level, 7'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
